// File: rtl/semaforo_pkg.sv
// Shared types and default thresholds for the traffic-light input conditioning block.
package semaforo_pkg;

    // Light vector as driven back by the controller, MSB first: AvR..BiciR.
    typedef struct packed {
        logic av_r;
        logic av_y;
        logic av_g;
        logic bv_r;
        logic bv_y;
        logic bv_g;
        logic bici_g;
        logic bici_r;
    } lights_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 4;
    localparam int unsigned DEF_MIN_GREEN_CYCLES = 16;
    localparam int unsigned DEF_YELLOW_CYCLES    = 4;
    localparam logic [7:0]  AGE_MAX              = 8'hFF;

    // True when two or more lamps of the same head are lit together.
    function automatic logic more_than_one(input logic r, input logic y, input logic g);
        return (r & y) | (r & g) | (y & g);
    endfunction

    // True for any combination the controller must never produce.
    function automatic logic lights_illegal(input lights_t l);
        return ((l.av_g | l.av_y) & (l.bv_g | l.bv_y))
             | (l.bici_g & l.bici_r)
             | more_than_one(l.av_r, l.av_y, l.av_g)
             | more_than_one(l.bv_r, l.bv_y, l.bv_g);
    endfunction

endpackage

// File: rtl/semaforo_debounce.sv
// Synchronizes one asynchronous input, filters it by run length and flags its rising edge.
module semaforo_debounce
    import semaforo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic       level_prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Two-flop synchronizer in front of everything else.
    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; the filtered level follows after a full run.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d   = 8'd0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Filtered level, its one-cycle history and the run counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= 8'd0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/semaforo_entradas.sv
// Input conditioning for the traffic-light controller: debounced detectors, latched
// requests, phase-age timer with expiry flag, and a sticky illegal-lights monitor.
module semaforo_entradas
    import semaforo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES    = DEF_YELLOW_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_av,
    input  logic raw_bv,
    input  logic btn_ped,
    input  logic btn_bici,
    input  logic AvR,
    input  logic AvY,
    input  logic AvG,
    input  logic BvR,
    input  logic BvY,
    input  logic BvG,
    input  logic BiciG,
    input  logic BiciR,
    output logic TAv,
    output logic TBv,
    output logic P,
    output logic B,
    output logic E,
    output logic err_lights
);

    lights_t    lights_i;
    lights_t    lights_q;
    logic [7:0] age_q;
    logic [7:0] age_d;
    logic       p_q, p_d;
    logic       b_q, b_d;
    logic       err_q, err_d;
    logic       ped_rise, bici_rise;
    logic       av_rise, bv_rise, ped_level, bici_level;
    logic       unused_debounce_outs;

    assign lights_i = {AvR, AvY, AvG, BvR, BvY, BvG, BiciG, BiciR};

    semaforo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_av (
        .clk(clk), .reset(reset), .raw_i(raw_av), .level_o(TAv), .rise_o(av_rise)
    );
    semaforo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bv (
        .clk(clk), .reset(reset), .raw_i(raw_bv), .level_o(TBv), .rise_o(bv_rise)
    );
    semaforo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ped (
        .clk(clk), .reset(reset), .raw_i(btn_ped), .level_o(ped_level), .rise_o(ped_rise)
    );
    semaforo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bici (
        .clk(clk), .reset(reset), .raw_i(btn_bici), .level_o(bici_level), .rise_o(bici_rise)
    );

    // Detector edges and button levels are not needed downstream.
    assign unused_debounce_outs = &{1'b0, av_rise, bv_rise, ped_level, bici_level};

    // Next state for phase age, requests and the error flag.
    always_comb begin
        age_d = age_q;
        if (lights_i != lights_q) begin
            age_d = 8'd0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 8'd1;
        end

        // Pedestrian request: a fresh press beats the end of avenue A green.
        p_d = p_q;
        if (ped_rise) begin
            p_d = 1'b1;
        end else if (lights_q.av_g && !lights_i.av_g) begin
            p_d = 1'b0;
        end

        // Bicycle request: a lit bicycle green always wins over a press.
        b_d = b_q;
        if (lights_i.bici_g) begin
            b_d = 1'b0;
        end else if (bici_rise) begin
            b_d = 1'b1;
        end

        err_d = err_q | lights_illegal(lights_i);
    end

    // Registered state of the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lights_q <= '0;
            age_q    <= 8'd0;
            p_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lights_q <= lights_i;
            age_q    <= age_d;
            p_q      <= p_d;
            b_q      <= b_d;
            err_q    <= err_d;
        end
    end

    assign P          = p_q;
    assign B          = b_q;
    assign err_lights = err_q;
    assign E          = (lights_q.av_y || lights_q.bv_y) ? (age_q >= 8'(YELLOW_CYCLES))
                                                         : (age_q >= 8'(MIN_GREEN_CYCLES));

endmodule

// File: doc/semaforo_entradas.md
SEMAFORO_ENTRADAS -- requirements
Module: semaforo_entradas

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a filtered input changes (range 1..255).
REQ-002 Parameter MIN_GREEN_CYCLES, 16, minimum phase age before E asserts in a non-yellow phase (range 1..255).
REQ-003 Parameter YELLOW_CYCLES, 4, minimum phase age before E asserts while any yellow is lit (range 1..255).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 raw_av, raw_bv  input  1 each  asynchronous vehicle detectors, avenue A and avenue B.
REQ-007 btn_ped, btn_bici  input  1 each  asynchronous pedestrian and bicycle push-buttons.
REQ-008 AvR, AvY, AvG, BvR, BvY, BvG, BiciG, BiciR  input  1 each  light vector driven back by the traffic-light controller.
REQ-009 TAv, TBv  output  1 each  debounced vehicle presence, avenue A and avenue B.
REQ-010 P, B  output  1 each  latched pedestrian and bicycle requests.
REQ-011 E  output  1  phase-timer expiry.
REQ-012 err_lights  output  1  sticky illegal-light-combination flag.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Debounce: the filtered value SHALL take the synchronized value only after they have differed for DEBOUNCE_CYCLES consecutive cycles; any matching cycle clears the run counter.
REQ-015 TAv and TBv SHALL equal the filtered raw_av and raw_bv levels.
REQ-016 P SHALL set on the cycle after a 0->1 edge of filtered btn_ped, and SHALL clear on the cycle after a light-vector change in which AvG goes 1->0.
REQ-017 B SHALL set on the cycle after a 0->1 edge of filtered btn_bici, and SHALL clear on the cycle after any cycle in which BiciG=1.
REQ-018 Simultaneous set and clear: P set wins; B clear wins. A request already set is unaffected by further presses.
REQ-019 Phase age: an 8-bit register captures the previous light vector; when the current vector differs, age loads 0, otherwise it increments, saturating at 255.
REQ-020 E SHALL be combinational from registered state: E=1 iff age >= YELLOW_CYCLES when AvY or BvY is registered high, else iff age >= MIN_GREEN_CYCLES.
REQ-021 E SHALL drop in the cycle after a light-vector change, irrespective of its previous value.
REQ-022 err_lights SHALL set one cycle after any of: (AvG or AvY) and (BvG or BvY); BiciG and BiciR; more than one of AvR/AvY/AvG; more than one of BvR/BvY/BvG; and SHALL hold until reset.

Reset
REQ-023 On reset, all synchronizer flops, filtered values, debounce counters, P, B, err_lights, age and the previous-vector register SHALL be 0, so TAv=TBv=P=B=E=err_lights=0.
REQ-024 Reset asserted mid-debounce or mid-phase SHALL abandon the count and latched requests; after release, the first non-zero light vector counts as a change (age=0).

Structure
REQ-025 The shared package semaforo_pkg SHALL hold the packed 8-bit light-vector type (bit order AvR..BiciR, MSB first) and the default threshold constants.
REQ-026 One sub-module, semaforo_debounce (synchronizer, debounce counter, filtered level, rising-edge pulse), SHALL be instantiated four times.

Verification
REQ-027 raw_av high 3 cycles then low, DEBOUNCE_CYCLES=4 -> TAv stays 0; high 10 cycles -> TAv=1 exactly 2+4 edges after first sample.
REQ-028 btn_bici pulse (debounced) -> B=1 and held; drive BiciG=1 for one cycle -> B=0 next cycle; press during BiciG=1 -> B stays 0.
REQ-029 P set, drive lights 00110001 -> 01010001 (AvG falls) -> P=0 next cycle; press coincident with that change -> P remains 1.
REQ-030 lights -> 01010001 held, YELLOW_CYCLES=4 -> E=0 for ages 0..3, E=1 from age 4; change vector -> E=0 next cycle.
REQ-031 non-yellow vector held 300 cycles -> age saturates at 255, E stays 1, no wrap.
REQ-032 drive AvG=1 and BvG=1 for one cycle then legal vector -> err_lights=1 and stays 1 until reset pulse, then 0.
